rsa_core_cached: RTL and testbench
==================================

# rsa_core_cached

Parametrised RSA modular-exponentiation core, `MOD_WIDTH` bits wide. It adds a one-entry cache of the Montgomery pre-factor R² mod N (R = 2^MOD_WIDTH), so back-to-back jobs with the same modulus skip the two-power-mod precompute. It also adds request-ID passthrough, cache flush and hit/miss statistics. It replaces the fixed-width RSA top as the engine behind the host request FIFO.

## Interface
Parameters:
- `MOD_WIDTH`, 256: width of msg, key, modulus, result; propagated to both sub-engines.
- `ID_WIDTH`, 4: width of the request tag.
- `CNT_WIDTH`, 16: width of the saturating statistics counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  request valid.
- `i_ready`  out  1  core can accept a request.
- `i_msg`  in  MOD_WIDTH  message.
- `i_key`  in  MOD_WIDTH  exponent.
- `i_modulus`  in  MOD_WIDTH  modulus N (odd).
- `i_id`  in  ID_WIDTH  request tag.
- `i_flush`  in  1  invalidate the cached pre-factor.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  downstream accepts the result.
- `o_crypto`  out  MOD_WIDTH  msg^key mod N.
- `o_id`  out  ID_WIDTH  tag of the result.
- `o_hit`  out  1  result was produced using the cached pre-factor.
- `o_hit_cnt`  out  CNT_WIDTH  saturating count of cache hits.
- `o_miss_cnt`  out  CNT_WIDTH  saturating count of cache misses.

## Operation
- **State IDLE**
  - `i_ready` = 1.
  - On `i_valid`, latch msg, key, modulus, id.
  - Hit (`cache_valid` && `i_modulus` == `cache_mod`): go to MONT and record hit = 1.
  - Miss: go to PRECOMP, pulse the two-power-mod `i_valid` for one cycle with power = 2·MOD_WIDTH, and record hit = 0.
- **State PRECOMP**
  - Two-power-mod `o_ready` is held at 1.
  - On its `o_valid`, write `cache_r2` ← result and `cache_mod` ← latched modulus, set `cache_valid`, and go to MONT.
- **State MONT**
  - Mont-exp `i_valid` = 1 with base = `cache_r2` and the latched msg/key/modulus.
  - On Mont `i_ready`, go to WAIT_OUT.
- **State WAIT_OUT**
  - `o_valid`/`o_crypto` come combinationally from Mont-exp.
  - `o_id`/`o_hit` are driven from registers.
  - Mont `o_ready` = `o_ready`.
  - On `o_valid` && `o_ready`, go to IDLE.
- **Counters**
  - Hit or miss count increments on the accept cycle.
  - Counters saturate at all-ones and are never cleared except by reset.
- **Flush**
  - `i_flush` clears `cache_valid` at the next edge.
  - If a flush coincides with a PRECOMP cache write, the flush wins and `cache_valid` = 0. `cache_r2` is still written, and the in-flight job uses it.
  - If a flush coincides with an IDLE accept, hit/miss is evaluated on the pre-flush `cache_valid`.
- **Data handling**
  - All arithmetic is unsigned MOD_WIDTH.
  - The modulus compare is a full-width equality.
  - An even or zero modulus is undefined; no checking is done.

## Timing
- Reset values:
  - All outputs 0.
  - state = IDLE, so `i_ready` = 1.
  - `cache_valid` = 0, `cache_mod`/`cache_r2` = 0.
  - Latched operands 0.
- Accept cycle T:
  - Hit: Mont `i_valid` is asserted from T+1.
  - Miss: two-power-mod `i_valid` is high in T+1 only.
- Mont `i_valid` is held until accepted. Input fields are stable from T+1 until the job completes.
- `o_valid` may rise no earlier than one cycle after Mont acceptance. `o_crypto`, `o_id` and `o_hit` stay stable while `o_valid` && !`o_ready`.
- Exactly one job is in flight; `i_ready` = 0 in PRECOMP, MONT and WAIT_OUT.
- Asynchronous reset mid-job:
  - Aborts the job.
  - Invalidates the cache.
  - Resets both sub-engines; no output is produced for the aborted job.

## Structure
- The shared package `RSA_pkg` holds:
  - the `State_t` enum (IDLE, PRECOMP, MONT, WAIT_OUT);
  - `MOD_WIDTH` default;
  - a parametrised key type used by all RSA blocks.
- Sub-modules: `RSATwoPowerMod` and `RSAMont`, both taking a `MOD_WIDTH` parameter.
- The cache plus counters form one natural sub-module, `rsa_r2_cache`:
  - inputs: lookup compare, write, flush;
  - outputs: hit, r2, stats.

## Test plan
- **Miss then hit.** MOD_WIDTH=32, N=0xC5B2_F6AB, key=65537, msg=0x1234_5678, id=3, then the same N with id=4.
  - Both results match the golden model.
  - o_hit = 0, then 1; hit_cnt = 1, miss_cnt = 1.
  - The second job shows no two-power-mod `i_valid` pulse.
- **Modulus change.** Alternate N1, N2, N1.
  - Three misses, `cache_mod` updated each time.
  - Correct results and ids 0, 1, 2.
- **Flush.** Assert `i_flush` between two same-N jobs.
  - Second job is a miss.
  - A flush coinciding with the PRECOMP write leaves `cache_valid` = 0 but the result stays correct.
- **Backpressure.** Hold `o_ready` = 0 for 20 cycles after `o_valid`.
  - o_crypto and o_id stay stable.
  - `i_ready` stays 0 until the handshake; IDLE the cycle after.
- **Reset mid-job.** Drop `rst` during PRECOMP and again during WAIT_OUT.
  - Outputs 0, `i_ready` = 1, counters 0.
  - The next same-N job is a miss.
- **Saturation.** CNT_WIDTH=2, run 5 hits; `o_hit_cnt` holds at 3.

Source files
------------

// File: rtl/rsa_core_cached_pkg.sv
// Shared RSA types: top-level FSM states, default width, key type, power-width helper.
package RSA_pkg;

  localparam int unsigned DefModWidth = 256;

  typedef enum logic [1:0] {
    StIdle,
    StPrecomp,
    StMont,
    StWaitOut
  } State_t;

  // Key/operand type at the default width; width-parametrised blocks use logic [MOD_WIDTH-1:0].
  typedef logic [DefModWidth-1:0] key_t;

  // Width needed to carry the power 2*w (R^2 = 2^(2w)).
  function automatic int unsigned pow_width(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/RSAMont.sv
// Montgomery modular exponentiation (left-to-right) with a bit-serial Montgomery multiplier.
module RSAMont
  import RSA_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = DefModWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [MOD_WIDTH-1:0] i_key,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result
);

  localparam int unsigned CntW = $clog2(MOD_WIDTH + 1);
  localparam int unsigned BitW = $clog2(MOD_WIDTH);

  typedef enum logic [2:0] {MIdle, MConvX, MConvOne, MSq, MMul, MFrom, MDone} mont_state_e;

  mont_state_e          st_q, st_d;
  logic [CntW-1:0]      mcnt_q, mcnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [MOD_WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d, acc_q, acc_d;
  logic [MOD_WIDTH-1:0] n_q, n_d, key_q, key_d, r2_q, r2_d, res_q, res_d;
  logic [MOD_WIDTH+1:0] s_q, s_d;

  logic [MOD_WIDTH+1:0] sum, n_ext, mres_full;
  logic [MOD_WIDTH-1:0] mres, sa, sb;
  logic                 mult_done, start, step, next_bit;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= MIdle;
      mcnt_q <= '0;
      bit_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
      acc_q  <= '0;
      n_q    <= '0;
      key_q  <= '0;
      r2_q   <= '0;
      res_q  <= '0;
      s_q    <= '0;
    end else begin
      st_q   <= st_d;
      mcnt_q <= mcnt_d;
      bit_q  <= bit_d;
      a_q    <= a_d;
      b_q    <= b_d;
      x_q    <= x_d;
      acc_q  <= acc_d;
      n_q    <= n_d;
      key_q  <= key_d;
      r2_q   <= r2_d;
      res_q  <= res_d;
      s_q    <= s_d;
    end
  end

  // Sequencing: x = msg*R, acc = R, then square/multiply per key bit, then leave Montgomery form.
  always_comb begin
    st_d     = st_q;
    mcnt_d   = mcnt_q;
    bit_d    = bit_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    acc_d    = acc_q;
    n_d      = n_q;
    key_d    = key_q;
    r2_d     = r2_q;
    res_d    = res_q;
    s_d      = s_q;
    start    = 1'b0;
    step     = 1'b0;
    next_bit = 1'b0;
    sa       = '0;
    sb       = '0;
    i_ready  = 1'b0;
    o_valid  = 1'b0;

    // s < 2N between steps, so s + b + N < 4N fits in MOD_WIDTH+2 bits.
    n_ext     = {2'b00, n_q};
    sum       = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    if (sum[0]) sum = sum + n_ext;
    mres_full = (s_q >= n_ext) ? (s_q - n_ext) : s_q;
    mres      = mres_full[MOD_WIDTH-1:0];
    mult_done = (mcnt_q == '0);

    unique case (st_q)
      MIdle: begin
        i_ready = 1'b1;
        if (i_valid) begin
          n_d   = i_modulus;
          key_d = i_key;
          r2_d  = i_base;
          start = 1'b1;
          sa    = i_msg;
          sb    = i_base;
          st_d  = MConvX;
        end
      end
      MConvX: begin
        if (!mult_done) step = 1'b1;
        else begin
          x_d   = mres;
          start = 1'b1;
          sa    = MOD_WIDTH'(1);
          sb    = r2_q;
          st_d  = MConvOne;
        end
      end
      MConvOne: begin
        if (!mult_done) step = 1'b1;
        else begin
          acc_d = mres;
          bit_d = BitW'(MOD_WIDTH - 1);
          start = 1'b1;
          sa    = mres;
          sb    = mres;
          st_d  = MSq;
        end
      end
      MSq: begin
        if (!mult_done) step = 1'b1;
        else begin
          acc_d = mres;
          if (key_q[bit_q]) begin
            start = 1'b1;
            sa    = mres;
            sb    = x_q;
            st_d  = MMul;
          end else begin
            next_bit = 1'b1;
          end
        end
      end
      MMul: begin
        if (!mult_done) step = 1'b1;
        else begin
          acc_d    = mres;
          next_bit = 1'b1;
        end
      end
      MFrom: begin
        if (!mult_done) step = 1'b1;
        else begin
          res_d = mres;
          st_d  = MDone;
        end
      end
      MDone: begin
        o_valid = 1'b1;
        if (o_ready) st_d = MIdle;
      end
      default: st_d = MIdle;
    endcase

    if (next_bit) begin
      start = 1'b1;
      sa    = mres;
      if (bit_q == '0) begin
        sb   = MOD_WIDTH'(1);
        st_d = MFrom;
      end else begin
        bit_d = bit_q - BitW'(1);
        sb    = mres;
        st_d  = MSq;
      end
    end

    if (start) begin
      a_d    = sa;
      b_d    = sb;
      s_d    = '0;
      mcnt_d = CntW'(MOD_WIDTH);
    end else if (step) begin
      s_d    = {1'b0, sum[MOD_WIDTH+1:1]};
      a_d    = {1'b0, a_q[MOD_WIDTH-1:1]};
      mcnt_d = mcnt_q - CntW'(1);
    end
  end

  assign o_result = res_q;

endmodule

// File: rtl/RSATwoPowerMod.sv
// Computes 2^power mod N by repeated modular doubling, one doubling per cycle.
module RSATwoPowerMod
  import RSA_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = DefModWidth,
  localparam int unsigned PowW     = pow_width(MOD_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [PowW-1:0]      i_power,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {TpIdle, TpRun, TpDone} tp_state_e;

  tp_state_e            st_q, st_d;
  logic [PowW-1:0]      cnt_q, cnt_d;
  logic [MOD_WIDTH-1:0] r_q, r_d, n_q, n_d;
  logic [MOD_WIDTH:0]   dbl;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= TpIdle;
      cnt_q <= '0;
      r_q   <= '0;
      n_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      r_q   <= r_d;
      n_q   <= n_d;
    end
  end

  // Next state: r < N, so 2r < 2N and one conditional subtract keeps r reduced.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    n_d     = n_q;
    i_ready = (st_q == TpIdle);
    o_valid = (st_q == TpDone);
    dbl     = {r_q, 1'b0};
    if (dbl >= {1'b0, n_q}) dbl = dbl - {1'b0, n_q};
    unique case (st_q)
      TpIdle: begin
        if (i_valid) begin
          r_d   = MOD_WIDTH'(1);
          cnt_d = i_power;
          n_d   = i_modulus;
          st_d  = TpRun;
        end
      end
      TpRun: begin
        if (cnt_q == '0) begin
          st_d = TpDone;
        end else begin
          r_d   = dbl[MOD_WIDTH-1:0];
          cnt_d = cnt_q - PowW'(1);
        end
      end
      TpDone: if (o_ready) st_d = TpIdle;
      default: st_d = TpIdle;
    endcase
  end

  assign o_result = r_q;

endmodule

// File: rtl/rsa_core_cached_r2_cache.sv
// One-entry R^2 mod N cache with saturating hit/miss statistics.
module rsa_r2_cache
  import RSA_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = DefModWidth,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_lookup_en,
  input  logic [MOD_WIDTH-1:0] i_lookup_mod,
  input  logic                 i_wr_en,
  input  logic [MOD_WIDTH-1:0] i_wr_mod,
  input  logic [MOD_WIDTH-1:0] i_wr_r2,
  input  logic                 i_flush,
  output logic                 o_hit,
  output logic [MOD_WIDTH-1:0] o_r2,
  output logic [CNT_WIDTH-1:0] o_hit_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt
);

  logic                 valid_q, valid_d;
  logic [MOD_WIDTH-1:0] mod_q, mod_d, r2_q, r2_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Cache entry and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      mod_q      <= '0;
      r2_q       <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      mod_q      <= mod_d;
      r2_q       <= r2_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Lookup uses the current (pre-flush) valid bit; flush beats a simultaneous write.
  always_comb begin
    o_hit      = valid_q && (i_lookup_mod == mod_q);
    valid_d    = valid_q;
    mod_d      = mod_q;
    r2_d       = r2_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (i_wr_en) begin
      mod_d   = i_wr_mod;
      r2_d    = i_wr_r2;
      valid_d = 1'b1;
    end
    if (i_flush) valid_d = 1'b0;
    if (i_lookup_en) begin
      if (o_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_r2       = r2_q;
  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: rtl/rsa_core_cached.sv
// RSA modexp engine with a cached Montgomery pre-factor, request tags and hit/miss stats.
module rsa_core_cached
  import RSA_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = DefModWidth,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [MOD_WIDTH-1:0] i_key,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [ID_WIDTH-1:0]  i_id,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_crypto,
  output logic [ID_WIDTH-1:0]  o_id,
  output logic                 o_hit,
  output logic [CNT_WIDTH-1:0] o_hit_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt
);

  localparam int unsigned PowW = pow_width(MOD_WIDTH);

  State_t               state_q, state_d;
  logic [MOD_WIDTH-1:0] msg_q, msg_d, key_q, key_d, mod_q, mod_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic                 hit_q, hit_d, tpm_valid_q, tpm_valid_d;

  logic                 accept, cache_hit, cache_wr;
  logic                 tpm_i_ready, tpm_o_valid, tpm_o_ready;
  logic                 mont_i_valid, mont_i_ready, mont_o_valid, mont_o_ready;
  logic [MOD_WIDTH-1:0] tpm_result, cache_r2, mont_result;

  // FSM state and latched job fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      msg_q       <= '0;
      key_q       <= '0;
      mod_q       <= '0;
      id_q        <= '0;
      hit_q       <= 1'b0;
      tpm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      mod_q       <= mod_d;
      id_q        <= id_d;
      hit_q       <= hit_d;
      tpm_valid_q <= tpm_valid_d;
    end
  end

  // Next state: a miss fires a single-cycle precompute request, a hit goes straight to Mont.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    key_d       = key_q;
    mod_d       = mod_q;
    id_d        = id_q;
    hit_d       = hit_q;
    tpm_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          msg_d = i_msg;
          key_d = i_key;
          mod_d = i_modulus;
          id_d  = i_id;
          hit_d = cache_hit;
          if (cache_hit) begin
            state_d = StMont;
          end else begin
            state_d     = StPrecomp;
            tpm_valid_d = 1'b1;
          end
        end
      end
      StPrecomp: if (tpm_o_valid) state_d = StMont;
      StMont:    if (mont_i_ready) state_d = StWaitOut;
      StWaitOut: if (o_valid && o_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign i_ready      = (state_q == StIdle) && tpm_i_ready;
  assign accept       = i_valid && i_ready;
  assign tpm_o_ready  = (state_q == StPrecomp);
  assign cache_wr     = tpm_o_valid && tpm_o_ready;
  assign mont_i_valid = (state_q == StMont);
  assign mont_o_ready = (state_q == StWaitOut) && o_ready;
  assign o_valid      = (state_q == StWaitOut) && mont_o_valid;
  assign o_crypto     = mont_result;
  assign o_id         = id_q;
  assign o_hit        = hit_q;

  rsa_r2_cache #(
    .MOD_WIDTH (MOD_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cache (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_en  (accept),
    .i_lookup_mod (i_modulus),
    .i_wr_en      (cache_wr),
    .i_wr_mod     (mod_q),
    .i_wr_r2      (tpm_result),
    .i_flush      (i_flush),
    .o_hit        (cache_hit),
    .o_r2         (cache_r2),
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  RSATwoPowerMod #(
    .MOD_WIDTH (MOD_WIDTH)
  ) u_tpm (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (tpm_valid_q),
    .i_ready   (tpm_i_ready),
    .i_power   (PowW'(2 * MOD_WIDTH)),
    .i_modulus (mod_q),
    .o_valid   (tpm_o_valid),
    .o_ready   (tpm_o_ready),
    .o_result  (tpm_result)
  );

  RSAMont #(
    .MOD_WIDTH (MOD_WIDTH)
  ) u_mont (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (mont_i_valid),
    .i_ready   (mont_i_ready),
    .i_base    (cache_r2),
    .i_msg     (msg_q),
    .i_key     (key_q),
    .i_modulus (mod_q),
    .o_valid   (mont_o_valid),
    .o_ready   (mont_o_ready),
    .o_result  (mont_result)
  );

endmodule

// File: tb/tb_rsa_core_cached.sv
// Directed bench for rsa_core_cached at MOD_WIDTH=32; a CNT_WIDTH=2 twin shares the stimulus.
module tb_rsa_core_cached;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 4;
  localparam logic [W-1:0] N1 = 32'hC5B2_F6AB;
  localparam logic [W-1:0] N2 = 32'd11;
  localparam logic [W-1:0] N3 = 32'd13;
  localparam logic [W-1:0] E  = 32'd65537;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_valid, i_flush, o_ready;
  logic [W-1:0]  i_msg, i_key, i_modulus;
  logic [IW-1:0] i_id;

  logic          i_ready, o_valid, o_hit;
  logic [W-1:0]  o_crypto;
  logic [IW-1:0] o_id;
  logic [15:0]   o_hit_cnt, o_miss_cnt;

  logic          s_i_ready, s_o_valid, s_o_hit;
  logic [W-1:0]  s_o_crypto;
  logic [IW-1:0] s_o_id;
  logic [1:0]    s_hit_cnt, s_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int tpm_pulses = 0;

  rsa_core_cached #(.MOD_WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_msg      (i_msg),
    .i_key      (i_key),
    .i_modulus  (i_modulus),
    .i_id       (i_id),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_crypto   (o_crypto),
    .o_id       (o_id),
    .o_hit      (o_hit),
    .o_hit_cnt  (o_hit_cnt),
    .o_miss_cnt (o_miss_cnt)
  );

  rsa_core_cached #(.MOD_WIDTH(W), .ID_WIDTH(IW), .CNT_WIDTH(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (s_i_ready),
    .i_msg      (i_msg),
    .i_key      (i_key),
    .i_modulus  (i_modulus),
    .i_id       (i_id),
    .i_flush    (i_flush),
    .o_valid    (s_o_valid),
    .o_ready    (o_ready),
    .o_crypto   (s_o_crypto),
    .o_id       (s_o_id),
    .o_hit      (s_o_hit),
    .o_hit_cnt  (s_hit_cnt),
    .o_miss_cnt (s_miss_cnt)
  );

  // Count precompute request pulses seen by the two-power-mod engine.
  always @(posedge clk) if (dut.tpm_valid_q) tpm_pulses <= tpm_pulses + 1;

  // Plain square-and-multiply reference, independent of the Montgomery datapath.
  function automatic logic [W-1:0] modexp(input logic [W-1:0] m, k, n);
    logic [63:0] r, b;
    r = 64'd1 % {32'd0, n};
    b = {32'd0, m} % {32'd0, n};
    for (int i = 0; i < W; i++) begin
      if (k[i]) r = (r * b) % {32'd0, n};
      b = (b * b) % {32'd0, n};
    end
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [W-1:0] m, k, n, input logic [IW-1:0] id, input string tag);
    int g = 0;
    while (i_ready !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".ready"}, i_ready, 1);
    i_msg     = m;
    i_key     = k;
    i_modulus = n;
    i_id      = id;
    i_valid   = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int g = 0;
    while (o_valid !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".valid"}, o_valid, 1);
  endtask

  task automatic job(input logic [W-1:0] m, k, n, input logic [IW-1:0] id,
                     input logic [W-1:0] exp_c, input logic exp_hit, input string tag);
    send_req(m, k, n, id, tag);
    wait_out(tag);
    check({tag, ".crypto"}, o_crypto, exp_c);
    check({tag, ".id"}, o_id, id);
    check({tag, ".hit"}, o_hit, exp_hit);
    @(negedge clk);
    check({tag, ".idle_after"}, i_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".o_valid"}, o_valid, 0);
    check({tag, ".i_ready"}, i_ready, 1);
    check({tag, ".o_crypto"}, o_crypto, 0);
    check({tag, ".o_id"}, o_id, 0);
    check({tag, ".o_hit"}, o_hit, 0);
    check({tag, ".hit_cnt"}, o_hit_cnt, 0);
    check({tag, ".miss_cnt"}, o_miss_cnt, 0);
    check({tag, ".cache_valid"}, dut.u_cache.valid_q, 0);
  endtask

  initial begin
    int p0;
    int g;
    rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; o_ready = 1'b1;
    i_msg = '0; i_key = '0; i_modulus = '0; i_id = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    // Miss then hit on the same modulus.
    p0 = tpm_pulses;
    job(32'h1234_5678, E, N1, 4'd3, modexp(32'h1234_5678, E, N1), 1'b0, "miss1");
    check("miss1.pulses", tpm_pulses - p0, 1);
    check("miss1.cache_mod", dut.u_cache.mod_q, N1);
    p0 = tpm_pulses;
    job(32'h1234_5678, E, N1, 4'd4, modexp(32'h1234_5678, E, N1), 1'b1, "hit1");
    check("hit1.pulses", tpm_pulses - p0, 0);
    check("hit1.hit_cnt", o_hit_cnt, 1);
    check("hit1.miss_cnt", o_miss_cnt, 1);

    // Four more hits: msg 0, 1, N-1 (odd key keeps -1) and a msg above N.
    job(32'd0, E, N1, 4'd5, 32'd0, 1'b1, "hit_m0");
    job(32'd1, E, N1, 4'd6, 32'd1, 1'b1, "hit_m1");
    job(N1 - 32'd1, E, N1, 4'd7, N1 - 32'd1, 1'b1, "hit_mneg1");
    job(32'hDEAD_BEEF, E, N1, 4'd8, modexp(32'hDEAD_BEEF, E, N1), 1'b1, "hit_big");
    check("sat.hit_cnt16", o_hit_cnt, 5);
    check("sat.hit_cnt2", s_hit_cnt, 3);
    check("sat.miss_cnt2", s_miss_cnt, 1);

    // Modulus change: N2, N3, N2 all miss.
    job(32'd2, 32'd10, N2, 4'd0, 32'd1, 1'b0, "chg0");
    check("chg0.cache_mod", dut.u_cache.mod_q, N2);
    job(32'd5, 32'd3, N3, 4'd1, 32'd8, 1'b0, "chg1");
    check("chg1.cache_mod", dut.u_cache.mod_q, N3);
    job(32'd7, 32'd0, N2, 4'd2, 32'd1, 1'b0, "chg2");
    check("chg2.cache_mod", dut.u_cache.mod_q, N2);
    check("chg.miss_cnt", o_miss_cnt, 4);
    check("chg.miss_cnt2", s_miss_cnt, 3);

    // Flush between two same-N jobs.
    job(32'd3, 32'd5, N2, 4'd3, 32'd1, 1'b1, "pre_flush");
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush.cache_valid", dut.u_cache.valid_q, 0);
    job(32'd2, 32'd5, N2, 4'd4, 32'd10, 1'b0, "post_flush");
    check("flush.hit_cnt", o_hit_cnt, 6);
    check("flush.miss_cnt", o_miss_cnt, 5);

    // Flush landing on the precompute write cycle.
    send_req(32'h1234_5678, E, N1, 4'd9, "fl_pc");
    g = 0;
    while (dut.tpm_o_valid !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("fl_pc.tpm_done", dut.tpm_o_valid, 1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("fl_pc.cache_valid", dut.u_cache.valid_q, 0);
    check("fl_pc.cache_mod", dut.u_cache.mod_q, N1);
    wait_out("fl_pc");
    check("fl_pc.crypto", o_crypto, modexp(32'h1234_5678, E, N1));
    check("fl_pc.id", o_id, 9);
    check("fl_pc.hit", o_hit, 0);
    @(negedge clk);
    job(32'd1, 32'd3, N1, 4'd10, 32'd1, 1'b0, "fl_pc_next");
    check("fl_pc.miss_cnt", o_miss_cnt, 7);

    // Backpressure: hold o_ready low for 20 cycles once o_valid is up.
    o_ready = 1'b0;
    send_req(32'hDEAD_BEEF, 32'd3, N1, 4'd11, "bp");
    wait_out("bp");
    for (int i = 0; i < 20; i++) begin
      check("bp.o_valid", o_valid, 1);
      check("bp.crypto", o_crypto, modexp(32'hDEAD_BEEF, 32'd3, N1));
      check("bp.id", o_id, 11);
      check("bp.i_ready", i_ready, 0);
      @(negedge clk);
    end
    check("bp.hit", o_hit, 1);
    o_ready = 1'b1;
    @(negedge clk);
    check("bp.idle_after", i_ready, 1);
    check("bp.o_valid_after", o_valid, 0);
    check("bp.hit_cnt", o_hit_cnt, 7);
    check("bp.hit_cnt2", s_hit_cnt, 3);

    // Reset during PRECOMP.
    send_req(32'd5, 32'd3, N3, 4'd12, "rst_pc");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("rst_pc");
    @(negedge clk);
    rst = 1'b1;
    job(32'd5, 32'd3, N3, 4'd12, 32'd8, 1'b0, "rst_pc_next");
    check("rst_pc.miss_cnt", o_miss_cnt, 1);
    check("rst_pc.hit_cnt", o_hit_cnt, 0);

    // Reset during WAIT_OUT.
    o_ready = 1'b0;
    send_req(32'd5, 32'd3, N3, 4'd13, "rst_wo");
    wait_out("rst_wo");
    check("rst_wo.hit", o_hit, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("rst_wo");
    o_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wo.no_output", o_valid, 0);
    job(32'd5, 32'd3, N3, 4'd14, 32'd8, 1'b0, "rst_wo_next");
    check("rst_wo.miss_cnt", o_miss_cnt, 1);
    check("rst_wo.hit_cnt", o_hit_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
